// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states
// and flag bit positions.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StMul  = 2'b10,
        StDone = 2'b11
    } alu_state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor shared by ADD/SUB execution and the multiply
// accumulate step.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff       = sub ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        // Overflow: operands share a sign that the sum does not.
        ovf         = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_engine.sv
// Multi-cycle ALU with start/ack handshake: single-cycle logic/arith ops and
// an iterative LSB-first shift-add unsigned multiply.
module alu_engine
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [2:0]       opsel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             ack_alu
);

    localparam logic [4:0] CntLast = 5'(WIDTH - 1);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, mplr_q, mplr_d;
    logic [2:0]       op_q;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_load, capture, mul_step;

    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_sub, add_cout, add_ovf;

    // acc_q[0] is already shifted into mplr_q; only acc_q[WIDTH:1] feeds back.
    logic unused_acc_lsb;
    assign unused_acc_lsb = acc_q[0];

    assign capture  = (state_q == StIdle) && start;
    assign mul_step = (state_q == StMul);
    assign add_a    = mul_step ? acc_q[WIDTH:1] : a_q;
    assign add_b    = mul_step ? (mplr_q[0] ? a_q : '0) : b_q;
    assign add_sub  = !mul_step && (op_q == OP_SUB);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_sub),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mplr_d   = mplr_q;
        out_load = 1'b0;
        res_d    = '0;
        res_hi_d = '0;
        flags_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (opsel == OP_MUL) ? StMul : StExec;
                end
            end
            StExec: begin
                state_d  = StDone;
                out_load = 1'b1;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        res_d           = add_sum;
                        flags_d[FLAG_C] = add_cout;
                        flags_d[FLAG_V] = add_ovf;
                    end
                    OP_AND:   res_d = a_q & b_q;
                    OP_OR:    res_d = a_q | b_q;
                    OP_XOR:   res_d = a_q ^ b_q;
                    OP_PASSB: res_d = b_q;
                    default:  res_d = '0;
                endcase
                if (op_q != OP_RSVD) begin
                    flags_d[FLAG_N] = res_d[WIDTH-1];
                    flags_d[FLAG_Z] = (res_d == '0);
                end
            end
            StMul: begin
                acc_d  = {add_cout, add_sum};
                mplr_d = {add_sum[0], mplr_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == CntLast) begin
                    // Final step lands straight in the output registers.
                    state_d         = StDone;
                    out_load        = 1'b1;
                    res_d           = mplr_d;
                    res_hi_d        = acc_d[WIDTH:1];
                    flags_d[FLAG_N] = res_d[WIDTH-1];
                    flags_d[FLAG_Z] = (res_d == '0) && (res_hi_d == '0);
                    flags_d[FLAG_C] = |res_hi_d;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            if (capture) begin
                a_q    <= a;
                b_q    <= b;
                op_q   <= opsel;
                mplr_q <= b;
                acc_q  <= '0;
                cnt_q  <= '0;
            end else begin
                acc_q  <= acc_d;
                mplr_q <= mplr_d;
                cnt_q  <= cnt_d;
            end
            if (out_load) begin
                res_q    <= res_d;
                res_hi_q <= res_hi_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign flags     = flags_q;
    assign busy      = (state_q != StIdle);
    assign ack_alu   = (state_q == StDone);

endmodule

// File: tb/tb_alu_engine.sv
// Directed table-driven bench for alu_engine plus handshake/reset sequences.
module tb_alu_engine;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic [2:0]  opsel;
    logic [15:0] a, b;
    logic [15:0] result, result_hi;
    logic [3:0]  flags;
    logic        busy, ack_alu;

    int n_checks = 0;
    int n_pass   = 0;

    alu_engine #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .opsel     (opsel),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .busy      (busy),
        .ack_alu   (ack_alu)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] hi;
        logic [3:0]  flg;  // {N,Z,C,V}
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one op; returns cycles from capture edge to ack (2 = EXEC then DONE).
    task automatic do_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output logic busy_seen);
        @(negedge clk);
        start = 1'b1; opsel = op; a = x; b = y;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        busy_seen = busy;
        while (!ack_alu && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat;
        logic        bs;
        logic        ack_any;
        logic [9:0]  ack_hist;

        vecs[0]  = '{OP_ADD,   16'h0001, 16'h0001, 16'h0002, 16'h0000, 4'h0, 2};
        vecs[1]  = '{OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'h9, 2};
        vecs[2]  = '{OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'h6, 2};
        vecs[3]  = '{OP_SUB,   16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 4'h8, 2};
        vecs[4]  = '{OP_SUB,   16'h0007, 16'h0007, 16'h0000, 16'h0000, 4'h6, 2};
        vecs[5]  = '{OP_SUB,   16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'h3, 2};
        vecs[6]  = '{OP_MUL,   16'h1234, 16'h5678, 16'h0060, 16'h0626, 4'h2, 17};
        vecs[7]  = '{OP_MUL,   16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'h4, 17};
        vecs[8]  = '{OP_MUL,   16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'h2, 17};
        vecs[9]  = '{OP_AND,   16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'h0, 2};
        vecs[10] = '{OP_OR,    16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 4'h0, 2};
        vecs[11] = '{OP_XOR,   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'h4, 2};
        vecs[12] = '{OP_PASSB, 16'h1234, 16'h8001, 16'h8001, 16'h0000, 4'h8, 2};
        vecs[13] = '{OP_RSVD,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'h0, 2};
        vecs[14] = '{OP_MUL,   16'h0003, 16'h0005, 16'h000F, 16'h0000, 4'h0, 17};

        rst_b = 1'b0; start = 1'b0; opsel = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", 32'(result), 32'h0);
        check("rst_result_hi", 32'(result_hi), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ack", 32'(ack_alu), 32'h0);
        rst_b = 1'b1;

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bs);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("v%0d_result_hi", i), 32'(result_hi), 32'(vecs[i].hi));
            check($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].flg));
            check($sformatf("v%0d_busy", i), 32'(bs), 32'h1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_ack_width", i), 32'(ack_alu), 32'h0);
        end

        // Start/operand churn while busy must not disturb a MUL in flight.
        @(negedge clk);
        start = 1'b1; opsel = OP_MUL; a = 16'h0007; b = 16'h0009;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (!ack_alu && lat < 40) begin
            start = 1'($urandom_range(0, 1));
            opsel = OP_ADD; a = 16'($urandom); b = 16'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_ign_latency", 32'(lat), 32'd17);
        check("busy_ign_result", {result_hi, result}, 32'h0000_003F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_ign_no_requeue", 32'({busy, ack_alu}), 32'h0);

        // Held start: captures in the IDLE cycle after each DONE.
        start = 1'b1; opsel = OP_ADD; a = 16'h0001; b = 16'h0002;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            ack_hist[i] = ack_alu;
        end
        start = 1'b0;
        check("held_start_ack_pattern", 32'(ack_hist), 32'(10'b00_1001_0010));
        check("held_start_result", 32'({flags, result}), 32'h0_0003);
        repeat (4) @(posedge clk);
        @(negedge clk);

        // Reset mid-MUL aborts without ack.
        start = 1'b1; opsel = OP_MUL; a = 16'h1234; b = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        ack_any = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            ack_any |= ack_alu;
        end
        check("midrst_result", 32'({result_hi, result}), 32'h0);
        check("midrst_flags", 32'(flags), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        rst_b = 1'b1;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            ack_any |= ack_alu;
        end
        check("midrst_no_ack", 32'(ack_any), 32'h0);
        do_op(OP_ADD, 16'h0001, 16'h0001, lat, bs);
        check("post_rst_latency", 32'(lat), 32'd2);
        check("post_rst_result", 32'(result), 32'h0002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_engine.md
# alu_engine

Multi-cycle 16-bit arithmetic/logic unit that sits directly downstream of the CPU control unit. It serves the address-offset and data operations that the control unit hands off through a start/acknowledge handshake. The control unit pulses `start` and then waits in its ALU-wait state until `ack_alu` is seen. This block captures operands and runs the operation, single-cycle or iterative shift-add multiply. It then presents the result and flags with a one-cycle `ack_alu` pulse.

## Interface
- `WIDTH`, 16, operand/result width; multiply iteration count equals `WIDTH`

- `clk` in 1 — single clock, rising edge
- `rst_b` in 1 — reset, synchronous, active-low
- `start` in 1 — operation request, sampled only in IDLE
- `opsel` in 3 — operation code, captured with `start`
- `a` in WIDTH — operand A, captured with `start`
- `b` in WIDTH — operand B, captured with `start`
- `result` out WIDTH — result (low half for MUL)
- `result_hi` out WIDTH — high half of MUL product; 0 for all other ops
- `flags` out 4 — {N, Z, C, V}
- `busy` out 1 — high in any state other than IDLE
- `ack_alu` out 1 — one-cycle done pulse; `result`/`flags` valid in that cycle

## Operation
- opsel codes:
  - 000 ADD: a+b
  - 001 SUB: a−b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MUL: unsigned, 2·WIDTH product
  - 110 PASSB: result = b (immediate move)
  - 111 reserved: result 0, flags 0, still acknowledged
- FSM states:
  - IDLE: `start`=1 captures a, b and opsel; goes to MUL for opsel 101, EXEC otherwise.
  - EXEC: computes the single-cycle op; goes to DONE.
  - MUL: shift-add, one multiplier bit per cycle, LSB first. Holds a WIDTH+1-bit accumulator plus a shifting multiplier register. A 5-bit iteration counter runs 0..WIDTH−1; the FSM goes to DONE after count WIDTH−1.
  - DONE: `ack_alu`=1; goes to IDLE unconditionally.
- Width and flag rules:
  - ADD: C = carry out of bit WIDTH−1.
  - SUB: computed as a+~b+1; C = 1 when a ≥ b unsigned (no borrow).
  - V = signed overflow for ADD/SUB; 0 for all other ops.
  - MUL: C = |result_hi.
  - N = result[WIDTH−1]; Z = (result == 0). For MUL, Z covers the full 2·WIDTH product.
  - Logic ops and PASSB: C = V = 0.
- `result`, `result_hi` and `flags` are registered; they update only on entry to DONE and hold until the next DONE.
- `start` while busy is ignored; it is not queued.
- `start` held high continuously: a new capture occurs in the IDLE cycle after DONE.
- Operand changes after capture have no effect on the operation in progress.

## Timing
- Reset (rst_b=0 at a clock edge): state IDLE; `result`, `result_hi`, `flags`, `ack_alu`, `busy` all 0; counter 0.
- Reset mid-operation aborts the operation; no `ack_alu` is produced.
- Single-cycle ops: `start` sampled at the edge ending cycle t; EXEC in t+1; DONE/`ack_alu` in t+2. Latency is 2 cycles; next start is accepted in t+3.
- MUL: MUL state occupies t+1 … t+WIDTH; DONE in t+WIDTH+1 (cycle t+17 for WIDTH=16).
- This satisfies the control unit's wait loop, which exits on the first cycle `ack_alu`=1. `ack_alu` is never high for two consecutive cycles.

## Structure
- Shared package `alu_pkg`:
  - opsel localparams (OP_ADD … OP_RSVD)
  - state encoding (IDLE, EXEC, MUL, DONE; binary, 2 bits)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- Sub-module `alu_addsub`: a WIDTH-bit adder with carry-in, `sub` invert control, carry-out and overflow outputs. It is shared by ADD/SUB in EXEC and by the MUL accumulate step, so one adder serves both.
- The top level holds the FSM, operand and multiplier registers, the counter, and the output registers.

## Test plan
- Reset: hold rst_b=0 for 3 cycles mid-MUL → all outputs 0, no `ack_alu`. After release, ADD 1+1 acks in 2 cycles with result 0x0002.
- ADD 0x7FFF+0x0001 → result 0x8000, flags N=1 Z=0 C=0 V=1; ADD 0xFFFF+0x0001 → 0x0000, Z=1 C=1 V=0; ack exactly 2 cycles after start.
- SUB 0x0005−0x0007 → 0xFFFE, N=1 C=0. SUB 0x0007−0x0007 → 0x0000, Z=1 C=1.
- MUL 0x1234×0x5678 → result_hi 0x0626, result 0x0060, C=1, ack in cycle t+17. MUL 0xFFFF×0 → 0, Z=1.
- Handshake: pulse `start` again while busy and hold operands changing → ignored, captured values used. Hold `start` high for 10 cycles with ADD → acks every 3 cycles, each ack one cycle wide.
- AND 0xF0F0&0x0FF0 → 0x00F0; PASSB b=0x8001 → 0x8001, N=1; opsel 111 → result 0, flags 0, ack still issued.
